add8_err_monitor: RTL

//   Online error-characterisation stage placed directly downstream of an 8-bit

---
 rtl/add8_err_monitor_if.sv | 13 +
 rtl/add8_err_monitor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/add8_err_monitor_if.sv
// Sample bus between the approximate adder under test and the error monitor.
// The master offers operand pairs with the adder's result; the slave accepts
// a sample on any cycle where in_valid and in_ready are both high.
interface add8_err_monitor_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [8:0] o_approx;

  modport master (output in_valid, output a, output b, output o_approx, input in_ready);
  modport slave  (input in_valid, input a, input b, input o_approx, output in_ready);
endinterface

// File: rtl/add8_err_monitor.sv
// Online error characterisation for an 8-bit approximate adder.
// Each accepted sample is compared against the exact sum. Over a run of
// N_SAMPLES samples the monitor accumulates the error count, the sum of |err|,
// the sum of err^2 (both saturating), and the worst-case error with the
// operands that first produced it.
module add8_err_monitor #(
  parameter int N_SAMPLES = 256,
  parameter int ACC_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  add8_err_monitor_if.slave    smp,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_W-1:0]     sample_cnt,
  output logic [ACC_W-1:0]     err_cnt,
  output logic [ACC_W-1:0]     abs_err_sum,
  output logic [ACC_W-1:0]     sq_err_sum,
  output logic [8:0]           max_err,
  output logic [7:0]           max_err_a,
  output logic [7:0]           max_err_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [ACC_W-1:0] LAST_IDX = ACC_W'(N_SAMPLES - 1);

  // |o - exact|; the difference spans -510..+511, so one extra bit of sign suffices
  function automatic logic [8:0] abs_err(input logic [8:0] o, input logic [8:0] exact);
    logic signed [9:0] d;
    d = $signed({1'b0, o}) - $signed({1'b0, exact});
    return d[9] ? 9'(-d) : d[8:0];
  endfunction

  // Saturating accumulate: once the sum reaches ACC_MAX it stays there
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [17:0]      inc);
    logic [ACC_W+18:0] s;
    s = {19'd0, acc} + {{(ACC_W+1){1'b0}}, inc};
    if (s > {19'd0, ACC_MAX}) return ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  state_t           state;
  logic             in_ready_r;
  logic [ACC_W-1:0] acc_cnt;
  logic             accept;
  logic [8:0]       exact_s;
  logic [8:0]       err_s;

  logic             vld_p1;
  logic [8:0]       err_p1;
  logic             nz_p1;
  logic [7:0]       a_p1;
  logic [7:0]       b_p1;

  logic             vld_p2;
  logic [17:0]      sq_p2;
  logic [8:0]       err_p2;
  logic             nz_p2;
  logic [7:0]       a_p2;
  logic [7:0]       b_p2;

  assign smp.in_ready = in_ready_r;
  assign accept       = smp.in_valid && in_ready_r;

  // Exact reference sum and absolute error of the sample on the bus
  always_comb begin
    exact_s = {1'b0, smp.a} + {1'b0, smp.b};
    err_s   = abs_err(smp.o_approx, exact_s);
  end

  // Datapath registers: error/operands in stage 1, squared error in stage 2
  always_ff @(posedge clk) begin
    // stage 1: registered error, non-zero flag and operands
    err_p1 <= err_s;
    nz_p1  <= (err_s != 9'd0);
    a_p1   <= smp.a;
    b_p1   <= smp.b;
    // stage 2: squared error alongside the stage-1 values
    sq_p2  <= 18'(err_p1) * 18'(err_p1);
    err_p2 <= err_p1;
    nz_p2  <= nz_p1;
    a_p2   <= a_p1;
    b_p2   <= b_p1;
  end

  // Run control FSM, valid pipeline and metric accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_r  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      acc_cnt     <= '0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      sample_cnt  <= '0;
      err_cnt     <= '0;
      abs_err_sum <= '0;
      sq_err_sum  <= '0;
      max_err     <= '0;
      max_err_a   <= '0;
      max_err_b   <= '0;
    end else begin
      done   <= 1'b0;
      vld_p1 <= accept;
      vld_p2 <= vld_p1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            in_ready_r  <= 1'b1;
            busy        <= 1'b1;
            acc_cnt     <= '0;
            sample_cnt  <= '0;
            err_cnt     <= '0;
            abs_err_sum <= '0;
            sq_err_sum  <= '0;
            max_err     <= '0;
            max_err_a   <= '0;
            max_err_b   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (acc_cnt == LAST_IDX) begin
              in_ready_r <= 1'b0;
              state      <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Results are final once neither pipeline stage holds a sample
          if (!vld_p1 && !vld_p2) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Accumulate stage: samples only reach here while RUN/DRAIN, never on a start edge
      if (vld_p2) begin
        sample_cnt  <= sample_cnt + 1'b1;
        err_cnt     <= err_cnt + ACC_W'(nz_p2);
        abs_err_sum <= sat_add(abs_err_sum, 18'(err_p2));
        sq_err_sum  <= sat_add(sq_err_sum, sq_p2);
        // Strict compare so ties keep the earliest operands and err==0 never updates
        if (err_p2 > max_err) begin
          max_err   <= err_p2;
          max_err_a <= a_p2;
          max_err_b <= b_p2;
        end
      end
    end
  end

endmodule
